cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/halt/single-step sequencer for the CPU core. Issues a one-cycle clock-enable (cpu_en) to
//  datapath and controlpath, replacing the free-running clock divider. Modes: free run at a
//  selectable rate, debounced single-instruction step, PC breakpoint. All moves to HALT or BREAK
//  occur at instruction boundaries.
// PARAMETERS
//  DIV_WIDTH      24     width of run-rate divider counter
//  DEB_CYCLES     50000  cycles step_btn must be stable to be accepted (1 ms @ 50 MHz)
//  PC_WIDTH       16     width of pc / bp_addr
// PORTS
//  clock        in   1         system clock (CLOCK_50 domain)
//  reset        in   1         asynchronous, active-low reset
//  run_req      in   1         async level (switch): 1 = run, 0 = halt
//  step_btn     in   1         async raw push-button, active-low (KEY style)
//  div_sel      in   5         run rate: one cpu_en per 2^div_sel cycles
//  bp_enable    in   1         breakpoint enable
//  bp_addr      in   PC_WIDTH  breakpoint address
//  pc           in   PC_WIDTH  current PC (registered in datapath)
//  fetch_instruction in 1      controlpath is in fetch state (registered); marks instruction boundary
//  cpu_en       out  1         one-cycle enable to CPU; CPU state advances only on clock edges with cpu_en=1
//  state        out  2         00 HALT, 01 RUN, 10 STEP, 11 BREAK
//  instr_count  out  16        instructions fetched since reset; wraps
// BEHAVIOUR
//  Reset (async, low): state=HALT, cpu_en=0, instr_count=0, div_cnt=0, synchronizers=released
//   (run_req=0, step=1), debounced step=1. Reset mid-operation aborts instantly; no pending step.
//  Inputs: run_req and step_btn each pass a 2-FF synchronizer (2-cycle latency). Debounce: counter
//   resets on any change of synced step; when it reaches DEB_CYCLES-1 with input unchanged, the
//   debounced value takes it. step_press = one-cycle pulse on debounced 1->0. Release: no event.
//  Divider: div_cnt clears on entry to RUN, increments every RUN cycle, wraps.
//   tick = (div_cnt & mask)==mask, mask=(1<<div_sel)-1. div_sel=0 -> tick every cycle.
//   div_sel >= DIV_WIDTH clamps to DIV_WIDTH-1.
//  boundary = fetch_instruction==1. cpu_en is combinational from internal state, tick,
//   fetch_instruction and pc (all registered) -> no combinational loop.
//  HALT: cpu_en=0. run_req=1 -> RUN (wins over step_press same cycle; press dropped);
//   else step_press -> STEP.
//  RUN: cpu_en=tick, except on a tick cycle with boundary=1:
//   bp_enable && pc==bp_addr && !bp_skip -> cpu_en=0, go BREAK (priority over halt);
//   else run_req=0 -> cpu_en=0, go HALT. Otherwise run_req=0 mid-instruction keeps pulsing.
//   bp_skip sets on RUN entry, clears after first cpu_en pulse -> resume never re-breaks at same PC.
//   step_press ignored in RUN.
//  STEP: cpu_en=1 every cycle (full speed). First cycle pulses unconditionally; afterwards first
//   cycle with boundary=1 -> cpu_en=0, go HALT. Breakpoints ignored. run_req ignored until HALT.
//  BREAK: cpu_en=0. run_req=0 -> HALT; step_press -> STEP. Resume = run_req 0 then 1.
//  instr_count += 1 on every cycle with cpu_en && boundary (16-bit wrap 0xFFFF->0x0000).
//  state output registered; reflects the current FSM state.
// TESTING (bench uses DEB_CYCLES=8; CPU model: fetch_instruction high every 3rd enabled cycle, pc+1 per instr)
//  1 Release reset, run_req=0, no button -> state=00, cpu_en=0 for 200 cycles, instr_count=0.
//  2 div_sel=2, run_req 0->1 -> state=01 3 cycles later; cpu_en every 4th cycle, first at div_cnt=3.
//  3 HALT, step_btn low 20 cycles -> exactly 3 cpu_en pulses, state back to 00, instr_count +1;
//    step_btn glitches of 5 cycles -> no pulses.
//  4 bp_enable=1, bp_addr=0x0010, run -> BREAK at pc=0x0010 with no cpu_en that cycle, pc holds;
//    run_req 0->1 -> RUN, passes 0x0010, instr_count keeps counting.
//  5 RUN, drop run_req mid-instruction -> pulses continue until boundary, then HALT; pc stable.
//  6 Assert reset during STEP -> cpu_en=0 same cycle, state=00, instr_count=0; step press pending lost.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer: issues the one-cycle cpu_en that advances the CPU core.
// Moves to HALT or BREAK only happen when the controlpath sits at an instruction boundary.
//
// state  | meaning
// HALT   | idle at a boundary, cpu_en held low
// RUN    | free run, one cpu_en per divider tick
// STEP   | full-speed enables until the next boundary
// BREAK  | stopped at breakpoint pc, waiting for run_req low or a step press
module cpu_run_ctrl #(
  parameter int DIV_WIDTH  = 24,
  parameter int DEB_CYCLES = 50000,
  parameter int PC_WIDTH   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run_req,
  input  logic                step_btn,
  input  logic [4:0]          div_sel,
  input  logic                bp_enable,
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                fetch_instruction,
  output logic                cpu_en,
  output logic [1:0]          state,
  output logic [15:0]         instr_count
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_t;

  run_state_t           cur_st;
  logic                 run_s1, run_s2;
  logic                 step_s1, step_s2, step_s3;
  logic                 step_deb;
  logic                 step_press;
  logic [DEB_W-1:0]     deb_cnt;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_mask;
  logic [4:0]           sel_eff;
  logic                 tick;
  logic                 bp_skip;
  logic                 bp_hit;
  logic                 step_first;

  // Button idles high; the debouncer reloads on every change of the synced level
  // and only adopts it once the down-counter has expired with the input steady.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_s1     <= 1'b0;
      run_s2     <= 1'b0;
      step_s1    <= 1'b1;
      step_s2    <= 1'b1;
      step_s3    <= 1'b1;
      step_deb   <= 1'b1;
      step_press <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      run_s1     <= run_req;
      run_s2     <= run_s1;
      step_s1    <= step_btn;
      step_s2    <= step_s1;
      step_s3    <= step_s2;
      step_press <= 1'b0;
      if (step_s2 != step_s3) begin
        deb_cnt <= DEB_LOAD;
      end else if (deb_cnt != '0) begin
        deb_cnt <= deb_cnt - DEB_W'(1);
      end else if (step_deb != step_s2) begin
        step_deb   <= step_s2;
        step_press <= step_deb & ~step_s2;
      end
    end
  end

  always_comb begin
    sel_eff = div_sel;
    if (int'(div_sel) >= DIV_WIDTH) sel_eff = 5'(DIV_WIDTH - 1);
  end

  always_comb begin
    div_mask = '0;
    for (int i = 0; i < DIV_WIDTH; i++) div_mask[i] = (i < int'(sel_eff));
  end

  assign tick   = ((div_cnt & div_mask) == div_mask);
  assign bp_hit = bp_enable && (pc == bp_addr) && !bp_skip;

  // Only registered terms feed cpu_en, so the CPU cannot close a loop through it.
  always_comb begin
    cpu_en = 1'b0;
    case (cur_st)
      ST_RUN:  cpu_en = tick && !(fetch_instruction && (bp_hit || !run_s2));
      ST_STEP: cpu_en = step_first || !fetch_instruction;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_st      <= ST_HALT;
      div_cnt     <= '0;
      bp_skip     <= 1'b0;
      step_first  <= 1'b0;
      instr_count <= '0;
    end else begin
      if (cpu_en && fetch_instruction) instr_count <= instr_count + 16'd1;
      case (cur_st)
        ST_HALT: begin
          if (run_s2) begin
            cur_st  <= ST_RUN;
            div_cnt <= '0;
            bp_skip <= 1'b1;
          end else if (step_press) begin
            cur_st     <= ST_STEP;
            step_first <= 1'b1;
          end
        end
        ST_RUN: begin
          div_cnt <= div_cnt + DIV_WIDTH'(1);
          // bp_skip lets a resume move off the breakpoint pc it stopped at.
          if (cpu_en) bp_skip <= 1'b0;
          if (tick && fetch_instruction) begin
            if (bp_hit) cur_st <= ST_BREAK;
            else if (!run_s2) cur_st <= ST_HALT;
          end
        end
        ST_STEP: begin
          step_first <= 1'b0;
          if (!step_first && fetch_instruction) cur_st <= ST_HALT;
        end
        ST_BREAK: begin
          if (!run_s2) begin
            cur_st <= ST_HALT;
          end else if (step_press) begin
            cur_st     <= ST_STEP;
            step_first <= 1'b1;
          end
        end
        default: cur_st <= ST_HALT;
      endcase
    end
  end

  assign state = cur_st;

endmodule
